shared_ram: RTL and testbench
=============================

# shared_ram

Parametrised single-port synchronous RAM shared by the data and instruction channels of the CPU, with per-cycle arbitration, byte-masked writes, per-channel read-valid handshakes and a hardware clear engine. It sits between the core's fetch and load/store units and replaces the tri-stated data bus with separate read and write buses.

## Interface

- DATA_W, 16, word width in bits; multiple of 8
- ADDR_W, 8, address width; depth is 2**ADDR_W words
- STARVE_LIM, 4, consecutive instruction-channel denials before the instruction channel is forced to win; 1..15
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  pulse; starts a full-memory zero sweep
- busy  out  1  high while the clear sweep runs
- d_req  in  1  data-channel request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data-channel word address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables; bit k writes byte k
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata holds the result of the previous-cycle granted read
- d_rdata  out  DATA_W  data read result
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid
- i_rdata  out  DATA_W  fetch result

## Operation

- One RAM access per cycle. The arbiter grants at most one of d_gnt and i_gnt.
- Priority: data wins by default. A 4-bit starvation counter increments on each cycle with i_req=1 and i_gnt=0, and clears on i_gnt or when i_req=0. When the counter equals STARVE_LIM and both channels request, the instruction channel wins.
- A granted write updates only the bytes with d_be=1. d_be=0 with a grant is a legal no-op that still consumes the cycle.
- A granted read captures mem[addr] into that channel's rdata register. rdata holds its value until the next granted read on the same channel.
- Requesters hold req and addr until they see gnt. Dropping req before the grant is allowed and has no side effect.
- Clear engine FSM, states IDLE and CLEAR:
  - IDLE→CLEAR on clr=1. The sweep address resets to 0.
  - CLEAR writes 0 to one word per cycle, in ascending address order.
  - After address 2**ADDR_W−1 is written, the FSM returns to IDLE, so the sweep takes exactly 2**ADDR_W cycles.
  - busy=1 in CLEAR. Both gnt outputs are 0 in CLEAR, and the starvation counter holds.
  - clr while in CLEAR is ignored.
- RAM contents are zero at configuration and are not affected by rst.

## Timing

- Reset values: busy=0, d_rvalid=0, i_rvalid=0, d_rdata=0, i_rdata=0, FSM=IDLE, starvation counter=0. While rst=1, d_gnt and i_gnt are 0.
- Read latency: 1 cycle. A grant at edge N gives rvalid=1 and valid rdata after edge N+1.
- rvalid is a single-cycle pulse per granted read. Back-to-back reads on one channel keep rvalid high continuously.
- Write followed by a read of the same address on the next cycle returns the new data.
- A data-read grant and a data write in consecutive cycles need no stall.
- rst asserted mid-sweep aborts the sweep: FSM=IDLE and memory is left partially cleared. rst with a read outstanding drops the pending rvalid.
- clr asserted in the same cycle as a request: clr wins, no grant is issued, and busy rises after that edge.

## Structure

- Package shared_ram_pkg:
  - clear-FSM state enum (IDLE, CLEAR)
  - default DATA_W and ADDR_W
  - starvation-counter width constant (4)
- Sub-module shared_ram_arb: combinational grant logic plus the starvation counter. Inputs are d_req, i_req, busy and rst; outputs are d_gnt, i_gnt.
- The RAM array is inferred as block RAM. The byte-enable write is coded as a per-byte loop.

## Test plan

- Write then read: write 16'hBEEF to addr 8'h10 with be=2'b11, then read 8'h10 → d_rvalid one cycle later with d_rdata=16'hBEEF.
- Byte mask: starting from 16'hBEEF at 8'h10, write 16'h1234 with be=2'b01, read back → 16'hBE34.
- Contention: d_req and i_req held high continuously with STARVE_LIM=4 → pattern d,d,d,d,i repeating; never both grants in one cycle.
- Clear: fill addr 0..3 with nonzero values, pulse clr → busy high for exactly 256 cycles, no grants during it; afterwards reads of addr 0..3 return 0.
- Reset mid-sweep: pulse clr, assert rst at sweep cycle 10 → busy=0 immediately; addr 0..9 read 0 and addr 200 keeps its prior value.
- Fetch stream: i_req held with i_addr 0,1,2 and d_req=0 → i_gnt every cycle, and i_rvalid high from the second cycle with the data in address order.

Source files
------------

// File: rtl/shared_ram_pkg.sv
// Shared definitions for the shared_ram block: default geometry, the
// clear-engine state encoding and the starvation-counter width.
package shared_ram_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;
  localparam int STARVE_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/shared_ram_arb.sv
// Single-grant arbiter between the data and instruction channels. Data wins
// by default; a starving instruction channel is forced through at STARVE_LIM.
module shared_ram_arb
  import shared_ram_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_req,
  input  logic i_req,
  input  logic busy,
  output logic d_gnt,
  output logic i_gnt
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

  logic [STARVE_W-1:0] r_starve;
  logic                w_i_win;

  always_comb begin
    d_gnt   = 1'b0;
    i_gnt   = 1'b0;
    w_i_win = i_req && (!d_req || (r_starve == LIM));
    if (!rst && !busy) begin
      i_gnt = w_i_win;
      d_gnt = d_req && !w_i_win;
    end
  end

  // The counter is frozen while the memory is blocked so a sweep does not
  // count against the fetch unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!busy) begin
      if (i_req && !i_gnt) begin
        if (r_starve != '1) begin
          r_starve <= r_starve + 1'b1;
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

endmodule

// File: rtl/shared_ram.sv
// Single-port RAM shared by the data and instruction channels, with byte-masked
// writes, registered per-channel read results and a full-memory clear engine.
module shared_ram
  import shared_ram_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  clr_state_e          r_state;
  clr_state_e          w_state_nxt;
  logic [ADDR_W-1:0]   r_sweep;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_d_rdata;
  logic [DATA_W-1:0]   r_i_rdata;
  logic                r_d_rvalid;
  logic                r_i_rvalid;
  logic                w_block;
  logic                w_d_wr;
  logic                w_d_rd;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [DATA_W-1:0]   w_rd_word;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clr) w_state_nxt = CLEAR;
      CLEAR:   if (r_sweep == '1) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= (r_state == CLEAR) ? r_sweep + 1'b1 : '0;
    end
  end

  assign busy = (r_state == CLEAR);

  // A clr pulse blocks grants on its own cycle so the sweep starts cleanly.
  assign w_block = busy | clr;

  shared_ram_arb #(
    .STARVE_LIM(STARVE_LIM)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .d_req (d_req),
    .i_req (i_req),
    .busy  (w_block),
    .d_gnt (d_gnt),
    .i_gnt (i_gnt)
  );

  assign w_d_wr    = d_gnt & d_we;
  assign w_d_rd    = d_gnt & ~d_we;
  assign w_rd_addr = i_gnt ? i_addr : d_addr;
  assign w_rd_word = r_mem[w_rd_addr];

  always_ff @(posedge clk) begin
    if (busy) begin
      r_mem[r_sweep] <= '0;
    end else if (w_d_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (d_be[b]) begin
          r_mem[d_addr][b*8 +: 8] <= d_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rdata  <= '0;
      r_i_rdata  <= '0;
    end else begin
      r_d_rvalid <= w_d_rd;
      r_i_rvalid <= i_gnt;
      if (w_d_rd) r_d_rdata <= w_rd_word;
      if (i_gnt)  r_i_rdata <= w_rd_word;
    end
  end

  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;

endmodule

// File: tb/tb_shared_ram.sv
// Self-checking bench for shared_ram: directed scenarios plus random traffic
// compared against an array-based reference model of the memory and arbiter.
module tb_shared_ram;

  localparam int LIM   = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst, clr, busy;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata, d_rdata;
  logic [1:0]  d_be;
  logic        i_req, i_gnt, i_rvalid;
  logic [7:0]  i_addr;
  logic [15:0] i_rdata;

  logic [15:0] memM [DEPTH];
  logic [15:0] dRdM, iRdM;
  logic        dRvM, iRvM;
  int          starveM, busyLeft;
  int          total, bad;

  shared_ram #(.DATA_W(16), .ADDR_W(8), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of traffic: predict grants from the arbitration rules, then the
  // registered results after the edge.
  task automatic applyStimulus(input logic clrV, input logic dReq, input logic dWe,
                               input logic [7:0] dAddr, input logic [15:0] dWd,
                               input logic [1:0] dBe, input logic iReq, input logic [7:0] iAddr);
    logic blocked, expI, expD;
    clr = clrV; d_req = dReq; d_we = dWe; d_addr = dAddr; d_wdata = dWd; d_be = dBe;
    i_req = iReq; i_addr = iAddr;
    #1;
    blocked = (busyLeft > 0) || clrV;
    expI = !blocked && iReq && (!dReq || starveM == LIM);
    expD = !blocked && dReq && !expI;
    checkOutput("d_gnt", d_gnt, expD);
    checkOutput("i_gnt", i_gnt, expI);
    checkOutput("one_gnt", d_gnt & i_gnt, 0);
    dRvM = expD && !dWe;
    if (dRvM) dRdM = memM[dAddr];
    iRvM = expI;
    if (iRvM) iRdM = memM[iAddr];
    if (expD && dWe)
      for (int b = 0; b < 2; b++)
        if (dBe[b]) memM[dAddr][b*8 +: 8] = dWd[b*8 +: 8];
    if (busyLeft > 0) begin
      memM[DEPTH - busyLeft] = 16'h0;
      busyLeft--;
    end else if (clrV) begin
      busyLeft = DEPTH;
    end
    if (!blocked) starveM = (iReq && !expI) ? starveM + 1 : 0;
    @(posedge clk);
    #1;
    checkOutput("d_rvalid", d_rvalid, dRvM);
    checkOutput("d_rdata", d_rdata, dRdM);
    checkOutput("i_rvalid", i_rvalid, iRvM);
    checkOutput("i_rdata", i_rdata, iRdM);
    checkOutput("busy", busy, busyLeft > 0);
  endtask

  task automatic resetModel();
    dRdM = 16'h0; iRdM = 16'h0; dRvM = 1'b0; iRvM = 1'b0;
    starveM = 0; busyLeft = 0;
  endtask

  initial begin
    logic dReq, iReq, dWe;
    logic [7:0]  dAddr, iAddr;
    logic [15:0] dWd;
    logic [1:0]  dBe;
    total = 0; bad = 0;
    for (int a = 0; a < DEPTH; a++) memM[a] = 16'h0;
    resetModel();
    $display("[TB] shared_ram bench start");

    rst = 1'b1; clr = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h0; d_wdata = 16'h0;
    d_be = 2'b00; i_req = 1'b1; i_addr = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_d_gnt", d_gnt, 0);
    checkOutput("rst_i_gnt", i_gnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_d_rvalid", d_rvalid, 0);
    checkOutput("rst_i_rvalid", i_rvalid, 0);
    checkOutput("rst_d_rdata", d_rdata, 0);
    checkOutput("rst_i_rdata", i_rdata, 0);
    d_req = 1'b0; i_req = 1'b0;
    rst = 1'b0;

    // Bring the array to a known all-zero state with a full sweep.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (DEPTH) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    applyStimulus(0, 1, 1, 8'h10, 16'hBEEF, 2'b11, 0, 0);
    applyStimulus(0, 1, 0, 8'h10, 16'h0, 2'b00, 0, 0);
    applyStimulus(0, 1, 1, 8'h10, 16'h1234, 2'b01, 0, 0);
    applyStimulus(0, 1, 0, 8'h10, 16'h0, 2'b00, 0, 0);
    applyStimulus(0, 1, 1, 8'h10, 16'h5678, 2'b00, 0, 0);
    applyStimulus(0, 1, 0, 8'h10, 16'h0, 2'b00, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 12; k++)
      applyStimulus(0, 1, 0, 8'h10, 16'h0, 2'b00, 1, 8'(k));

    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 8'(k));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Clear with both requesters waiting throughout the sweep.
    for (int a = 0; a < 4; a++) applyStimulus(0, 1, 1, 8'(a), 16'hA5A0 + 16'(a), 2'b11, 0, 0);
    applyStimulus(1, 1, 0, 8'h2, 16'h0, 2'b00, 1, 8'h3);
    repeat (DEPTH) applyStimulus(0, 1, 0, 8'h2, 16'h0, 2'b00, 1, 8'h3);
    for (int a = 0; a < 4; a++) applyStimulus(0, 1, 0, 8'(a), 16'h0, 2'b00, 0, 0);

    for (int a = 0; a < 12; a++) applyStimulus(0, 1, 1, 8'(a), 16'h1100 + 16'(a), 2'b11, 0, 0);
    applyStimulus(0, 1, 1, 8'd200, 16'hC8C8, 2'b11, 0, 0);
    applyStimulus(0, 1, 0, 8'd5, 16'h0, 2'b00, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    clr = 1'b0; d_req = 1'b0; i_req = 1'b0;
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput("midsweep_busy", busy, 0);
    checkOutput("midsweep_d_rvalid", d_rvalid, 0);
    checkOutput("midsweep_d_rdata", d_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 12; a++) applyStimulus(0, 1, 0, 8'(a), 16'h0, 2'b00, 0, 0);
    applyStimulus(0, 1, 0, 8'd200, 16'h0, 2'b00, 0, 0);

    dReq = 1'b0; dWe = 1'b0; dAddr = 8'h0; dWd = 16'h0; dBe = 2'b00;
    iReq = 1'b0; iAddr = 8'h0;
    for (int n = 0; n < 400; n++) begin
      if (!dReq || d_gnt || $urandom_range(7) == 0) begin
        dReq  = 1'($urandom_range(1));
        dWe   = 1'($urandom_range(1));
        dAddr = 8'($urandom_range(15));
        dWd   = 16'($urandom);
        dBe   = 2'($urandom_range(3));
      end
      if (!iReq || i_gnt || $urandom_range(7) == 0) begin
        iReq  = ($urandom_range(3) != 0);
        iAddr = 8'($urandom_range(15));
      end
      applyStimulus(0, dReq, dWe, dAddr, dWd, dBe, iReq, iAddr);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
